div_sqrt_issue_queue: RTL and testbench



---
 rtl/div_sqrt_issue_queue.sv | 157 +++++++++++++++
 tb/tb_div_sqrt_issue_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sqrt_issue_queue.sv
// rtl/div_sqrt_issue_queue.sv - tagged request FIFO and result register around divSqrtFN (optional DIV_SQRT_ISSUE_BYPASS_EN)
module div_sqrt_issue_queue #(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int depth    = 4,
  parameter int tagWidth = 4,
  localparam int W        = expWidth + sigWidth,
  localparam int ptrWidth = $clog2(depth),
  localparam int cntWidth = $clog2(depth) + 1
) (
  input  logic                nReset,
  input  logic                clock,
  output logic                enqReady,
  input  logic                enqValid,
  input  logic                enqSqrtOp,
  input  logic [W-1:0]        enqA,
  input  logic [W-1:0]        enqB,
  input  logic [2:0]          enqRoundingMode,
  input  logic [tagWidth-1:0] enqTag,
  input  logic                dsInReady,
  output logic                dsInValid,
  output logic                dsSqrtOp,
  output logic [W-1:0]        dsA,
  output logic [W-1:0]        dsB,
  output logic [2:0]          dsRoundingMode,
  input  logic                dsOutValid,
  input  logic                dsSqrtOpOut,
  input  logic [W-1:0]        dsOut,
  input  logic [4:0]          dsExceptionFlags,
  output logic                resValid,
  input  logic                resReady,
  output logic                resSqrtOp,
  output logic [W-1:0]        resOut,
  output logic [4:0]          resExceptionFlags,
  output logic [tagWidth-1:0] resTag,
  output logic [cntWidth-1:0] count,
  output logic                protocolErr
);

  logic                fifoSqrt [depth];
  logic [W-1:0]        fifoA    [depth];
  logic [W-1:0]        fifoB    [depth];
  logic [2:0]          fifoRm   [depth];
  logic [tagWidth-1:0] fifoTag  [depth];

  logic [ptrWidth-1:0] wrPtr;
  logic [ptrWidth-1:0] rdPtr;
  logic                inFlight;
  logic [tagWidth-1:0] tagReg;

  logic                resPop;
  logic                issueOk;
  logic                fifoEmpty;
  logic                enqFire;
  logic                useBypass;
  logic                headPop;
  logic                fifoWrite;
  logic [tagWidth-1:0] issueTag;
  logic                capture;

  // Full flag depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign enqReady = (count != cntWidth'(depth));

  // Issue decision: one op in flight, and the result register must be free (or draining) on return.
  always_comb begin
    resPop    = resValid && resReady;
    issueOk   = dsInReady && !inFlight && (!resValid || resPop);
    fifoEmpty = (count == '0);
    enqFire   = enqValid && enqReady;
    useBypass = 1'b0;
`ifdef DIV_SQRT_ISSUE_BYPASS_EN
    useBypass = fifoEmpty && issueOk && enqFire;
`endif
    headPop   = !fifoEmpty && issueOk;
    fifoWrite = enqFire && !useBypass;
    dsInValid = headPop || useBypass;
    capture   = dsOutValid && inFlight;
    if (useBypass) begin
      dsSqrtOp       = enqSqrtOp;
      dsA            = enqA;
      dsB            = enqB;
      dsRoundingMode = enqRoundingMode;
      issueTag       = enqTag;
    end else begin
      dsSqrtOp       = fifoSqrt[rdPtr];
      dsA            = fifoA[rdPtr];
      dsB            = fifoB[rdPtr];
      dsRoundingMode = fifoRm[rdPtr];
      issueTag       = fifoTag[rdPtr];
    end
  end

  // Request storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (fifoWrite) begin
      fifoSqrt[wrPtr] <= enqSqrtOp;
      fifoA[wrPtr]    <= enqA;
      fifoB[wrPtr]    <= enqB;
      fifoRm[wrPtr]   <= enqRoundingMode;
      fifoTag[wrPtr]  <= enqTag;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (fifoWrite) wrPtr <= wrPtr + ptrWidth'(1);
      if (headPop)   rdPtr <= rdPtr + ptrWidth'(1);
      case ({fifoWrite, headPop})
        2'b10:   count <= count + cntWidth'(1);
        2'b01:   count <= count - cntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // In-flight tracking; issue needs !inFlight and capture needs inFlight, so they never coincide.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      inFlight <= 1'b0;
      tagReg   <= '0;
    end else if (dsInValid) begin
      inFlight <= 1'b1;
      tagReg   <= issueTag;
    end else if (capture) begin
      inFlight <= 1'b0;
    end
  end

  // Result register; a stray unit pulse is dropped and flagged stickily.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      resValid          <= 1'b0;
      resSqrtOp         <= 1'b0;
      resOut            <= '0;
      resExceptionFlags <= '0;
      resTag            <= '0;
      protocolErr       <= 1'b0;
    end else begin
      if (capture) begin
        resValid          <= 1'b1;
        resSqrtOp         <= dsSqrtOpOut;
        resOut            <= dsOut;
        resExceptionFlags <= dsExceptionFlags;
        resTag            <= tagReg;
      end else if (resPop) begin
        resValid <= 1'b0;
      end
      if (dsOutValid && !inFlight) protocolErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_sqrt_issue_queue.sv
// tb/tb_div_sqrt_issue_queue.sv - randomized bench with queue-based reference model and emulated divide/sqrt unit
module tb_div_sqrt_issue_queue;

  localparam int W = 32;
  localparam int depth = 4;
`ifdef DIV_SQRT_ISSUE_BYPASS_EN
  localparam logic bypassOn = 1'b1;
`else
  localparam logic bypassOn = 1'b0;
`endif

  logic          nReset, clock;
  logic          enqReady, enqValid, enqSqrtOp;
  logic [W-1:0]  enqA, enqB;
  logic [2:0]    enqRoundingMode;
  logic [3:0]    enqTag;
  logic          dsInReady, dsInValid, dsSqrtOp;
  logic [W-1:0]  dsA, dsB;
  logic [2:0]    dsRoundingMode;
  logic          dsOutValid, dsSqrtOpOut;
  logic [W-1:0]  dsOut;
  logic [4:0]    dsExceptionFlags;
  logic          resValid, resReady, resSqrtOp;
  logic [W-1:0]  resOut;
  logic [4:0]    resExceptionFlags;
  logic [3:0]    resTag;
  logic [2:0]    count;
  logic          protocolErr;

  int checks = 0;
  int errors = 0;
  logic holdReady = 1'b0;
  logic injectStray = 1'b0;
  int unitLat = 2;

  typedef struct {logic sqrt; logic [31:0] a; logic [31:0] b; logic [2:0] rm; logic [3:0] tag;} reqT;
  typedef struct {logic sqrt; logic [31:0] out; logic [4:0] flags; logic [3:0] tag;} resT;
  reqT reqQ[$];
  resT expQ[$];

  div_sqrt_issue_queue dut (
    .nReset(nReset), .clock(clock), .enqReady(enqReady), .enqValid(enqValid),
    .enqSqrtOp(enqSqrtOp), .enqA(enqA), .enqB(enqB), .enqRoundingMode(enqRoundingMode),
    .enqTag(enqTag), .dsInReady(dsInReady), .dsInValid(dsInValid), .dsSqrtOp(dsSqrtOp),
    .dsA(dsA), .dsB(dsB), .dsRoundingMode(dsRoundingMode), .dsOutValid(dsOutValid),
    .dsSqrtOpOut(dsSqrtOpOut), .dsOut(dsOut), .dsExceptionFlags(dsExceptionFlags),
    .resValid(resValid), .resReady(resReady), .resSqrtOp(resSqrtOp), .resOut(resOut),
    .resExceptionFlags(resExceptionFlags), .resTag(resTag), .count(count),
    .protocolErr(protocolErr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Stand-in for divSqrtFN: exact for x/1.0 and sqrt of a negative, arbitrary but deterministic otherwise.
  function automatic logic [36:0] unitResult(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (!s && b == 32'h3F800000) return {5'b00000, a};
    if (s && a[31] && a[30:0] != 31'd0) return {5'b10000, 32'h7FC00000};
    return {a[4:0] ^ b[9:5], a ^ {b[15:0], b[31:16]} ^ {31'd0, s}};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor/scoreboard at negedge, then the emulated unit drives its side after the posedge.
  initial begin : unitModel
    logic issueSeen, busy, pSqrt;
    logic [31:0] pA, pB;
    int busyCnt;
    reqT r;
    resT e;
    busy = 1'b0; busyCnt = 0; pSqrt = 1'b0; pA = '0; pB = '0;
    dsInReady = 1'b1; dsOutValid = 1'b0; dsSqrtOpOut = 1'b0; dsOut = '0; dsExceptionFlags = '0;
    forever begin
      @(negedge clock);
      issueSeen = 1'b0;
      if (!nReset) begin
        reqQ.delete();
        expQ.delete();
      end else begin
        check("count", count, reqQ.size());
        check("enqReady", enqReady, reqQ.size() != depth);
        if (enqValid && enqReady)
          reqQ.push_back('{enqSqrtOp, enqA, enqB, enqRoundingMode, enqTag});
        if (dsInValid) begin
          issueSeen = 1'b1;
          pSqrt = dsSqrtOp; pA = dsA; pB = dsB;
          check("issueHasRequest", reqQ.size() != 0, 1);
          if (reqQ.size() != 0) begin
            r = reqQ.pop_front();
            check("issueA", dsA, r.a);
            check("issueB", dsB, r.b);
            check("issueSqrt", dsSqrtOp, r.sqrt);
            check("issueRm", dsRoundingMode, r.rm);
            {e.flags, e.out} = unitResult(r.sqrt, r.a, r.b);
            e.sqrt = r.sqrt;
            e.tag = r.tag;
            expQ.push_back(e);
          end
        end
        if (resValid && resReady) begin
          check("resExpected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("resOut", resOut, e.out);
            check("resFlags", resExceptionFlags, e.flags);
            check("resTag", resTag, e.tag);
            check("resSqrt", resSqrtOp, e.sqrt);
          end
        end
      end
      @(posedge clock);
      #1;
      dsOutValid = 1'b0;
      if (issueSeen) begin
        busy = 1'b1;
        busyCnt = unitLat;
      end
      if (busy) begin
        if (busyCnt == 0) begin
          dsOutValid = 1'b1;
          dsSqrtOpOut = pSqrt;
          {dsExceptionFlags, dsOut} = unitResult(pSqrt, pA, pB);
          busy = 1'b0;
        end else begin
          busyCnt--;
        end
      end else if (injectStray) begin
        dsOutValid = 1'b1;
        injectStray = 1'b0;
      end
      dsInReady = !busy && !holdReady;
    end
  end

  task automatic checkResetValues(input string tag);
    check({tag, "EnqReady"}, enqReady, 1);
    check({tag, "DsInValid"}, dsInValid, 0);
    check({tag, "ResValid"}, resValid, 0);
    check({tag, "Count"}, count, 0);
    check({tag, "ProtocolErr"}, protocolErr, 0);
    check({tag, "ResOut"}, resOut, 0);
    check({tag, "ResFlags"}, resExceptionFlags, 0);
    check({tag, "ResTag"}, resTag, 0);
    check({tag, "ResSqrt"}, resSqrtOp, 0);
  endtask

  task automatic enq(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n = 0;
    enqValid = 1'b1; enqSqrtOp = s; enqA = a; enqB = b;
    enqRoundingMode = 3'($urandom_range(0, 4)); enqTag = tag;
    while (!enqReady && n < 100) begin
      cyc();
      n++;
    end
    check("enqAccept", enqReady, 1);
    cyc();
    enqValid = 1'b0;
  endtask

  task automatic waitRes(input string tag);
    int n = 0;
    while (!resValid && n < 100) begin
      cyc();
      n++;
    end
    check(tag, resValid, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    resReady = 1'b1; holdReady = 1'b0; enqValid = 1'b0;
    while ((reqQ.size() + expQ.size()) != 0 && n < 400) begin
      cyc();
      n++;
    end
    check(tag, reqQ.size() + expQ.size(), 0);
    cyc();
    resReady = 1'b0;
  endtask

  initial begin : mainSeq
    int got, n;
    nReset = 1'b0; enqValid = 1'b0; enqSqrtOp = 1'b0; enqA = '0; enqB = '0;
    enqRoundingMode = '0; enqTag = '0; resReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkResetValues("reset");
    nReset = 1'b1;
    cyc();

    // Single divide 3.0 / 1.0, tag 5, RNE
    enqValid = 1'b1; enqSqrtOp = 1'b0; enqA = 32'h40400000; enqB = 32'h3F800000;
    enqRoundingMode = 3'd0; enqTag = 4'd5;
    @(negedge clock);
    check("issueSameCycle", dsInValid, bypassOn);
    cyc();
    enqValid = 1'b0;
    @(negedge clock);
    check("issueNextCycle", dsInValid, !bypassOn);
    cyc();
    waitRes("divResValid");
    check("divOut", resOut, 32'h40400000);
    check("divFlags", resExceptionFlags, 0);
    check("divTag", resTag, 5);
    check("divSqrtOp", resSqrtOp, 0);
    resReady = 1'b1;
    cyc();
    resReady = 1'b0;

    // Fill while the unit refuses, then drain in order
    holdReady = 1'b1;
    cyc(); cyc();
    for (int i = 1; i <= 4; i++) enq(1'($urandom_range(0, 1)), $urandom, $urandom, 4'(i));
    @(negedge clock);
    check("fullCount", count, 4);
    check("fullEnqReady", enqReady, 0);
    cyc();
    holdReady = 1'b0; resReady = 1'b1;
    got = 0; n = 0;
    while (got < 4 && n < 200) begin
      @(negedge clock);
      if (resValid && resReady) begin
        check($sformatf("orderTag%0d", got + 1), resTag, got + 1);
        got++;
      end
      cyc();
      n++;
    end
    check("orderDone", got, 4);
    resReady = 1'b0;
    drain("fillDrain");

    // Held result stalls issue; the pop cycle issues the next op
    holdReady = 1'b1;
    cyc(); cyc();
    for (int i = 1; i <= 4; i++) enq(1'b0, $urandom, $urandom, 4'(8 + i));
    holdReady = 1'b0;
    waitRes("stallFirstRes");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stallNoIssue", dsInValid, 0);
      cyc();
    end
    check("stallQueued", count, 3);
    resReady = 1'b1;
    @(negedge clock);
    check("issueOnPop", dsInValid, 1);
    cyc();
    resReady = 1'b0;
    drain("stallDrain");

    // sqrt(-1.0)
    enq(1'b1, 32'hBF800000, 32'h0, 4'd7);
    waitRes("sqrtResValid");
    check("sqrtOut", resOut, 32'h7FC00000);
    check("sqrtFlags", resExceptionFlags, 5'b10000);
    check("sqrtTag", resTag, 7);
    check("sqrtSqrtOp", resSqrtOp, 1);
    drain("sqrtDrain");

    // Stray result pulse with nothing in flight
    injectStray = 1'b1;
    repeat (4) cyc();
    check("strayProtocolErr", protocolErr, 1);
    check("strayResValid", resValid, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      enqValid = 1'($urandom_range(0, 1));
      enqSqrtOp = 1'($urandom_range(0, 1));
      enqA = $urandom;
      enqB = ($urandom_range(0, 3) == 0) ? 32'h3F800000 : $urandom;
      enqRoundingMode = 3'($urandom_range(0, 4));
      enqTag = 4'($urandom_range(0, 15));
      resReady = ($urandom_range(0, 3) != 0);
      holdReady = ($urandom_range(0, 4) == 0);
      unitLat = $urandom_range(0, 3);
      cyc();
    end
    drain("randomDrain");
    check("protocolErrSticky", protocolErr, 1);

    // Reset while one op is in flight and two are queued
    holdReady = 1'b1; unitLat = 8;
    cyc(); cyc();
    for (int i = 1; i <= 3; i++) enq(1'b0, $urandom, $urandom, 4'(i));
    holdReady = 1'b0;
    n = 0;
    while (expQ.size() == 0 && n < 50) begin
      cyc();
      n++;
    end
    check("midIssued", expQ.size(), 1);
    cyc();
    check("midQueued", count, 2);
    #3 nReset = 1'b0;
    #1 checkResetValues("asyncReset");
    repeat (2) @(posedge clock);
    #1 nReset = 1'b1;
    resReady = 1'b1;
    repeat (15) cyc();
    check("postResetResValid", resValid, 0);
    check("postResetProtocolErr", protocolErr, 1);
    check("postResetCount", count, 0);
    resReady = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
